// File: rtl/ex3_pkg.sv
// Shared Excess-3 definitions used by both the encoder and decoder sides of
// the BCD/Excess-3 path: code limits, the invalid-digit marker, the packer
// FSM states and the self-complement helper.
package ex3_pkg;

   localparam logic [3:0] EX3_OFFSET  = 4'd3;
   localparam logic [3:0] EX3_MIN     = 4'd3;
   localparam logic [3:0] EX3_MAX     = 4'd12;
   localparam logic [3:0] BCD_INVALID = 4'hF;

   typedef enum logic {
      COLLECT = 1'b0,
      OUTPUT  = 1'b1
   } pack_state_e;

   // Excess-3 is self-complementing: inverting the code of d gives the code
   // of 9-d, so subtracting the usual offset afterwards yields the nine's
   // complement in BCD.
   function automatic logic [3:0] ex3_nines_comp(input logic [3:0] ex3);
      return ~ex3;
   endfunction

endpackage

// File: rtl/ex3_digit_decode.sv
// Combinational Excess-3 to BCD digit decoder with optional nine's
// complement. Codes outside 3..12 decode to BCD_INVALID and raise err;
// validity is always judged on the raw code, before any complementing.
module ex3_digit_decode
   import ex3_pkg::*;
(
   input  logic [3:0] ex3,
   input  logic       comp,
   output logic [3:0] bcd,
   output logic       err
);

   logic       code_ok;
   logic [3:0] code_src;

   assign code_ok  = (ex3 >= EX3_MIN) && (ex3 <= EX3_MAX);
   assign code_src = comp ? ex3_nines_comp(ex3) : ex3;
   assign bcd      = code_ok ? (code_src - EX3_OFFSET) : BCD_INVALID;
   assign err      = ~code_ok;

endmodule

// File: rtl/ex3_to_bcd_packer.sv
// Collects a valid/ready stream of Excess-3 digits, decodes each to BCD and
// packs up to NUM_DIGITS of them into one right-aligned word (nibble 0 holds
// the most recent digit). A word closes on in_last or when full, is then held
// until the sink takes it, and only afterwards is new input accepted.
// Build option: define EX3_NINES_COMP_EN to add the in_comp port, which
// stores the nine's complement of the accompanying digit.
module ex3_to_bcd_packer
   import ex3_pkg::*;
#(
   parameter  int NUM_DIGITS = 4,
   localparam int CW         = $clog2(NUM_DIGITS + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic [3:0]              in_ex3,
   input  logic                    in_last,
`ifdef EX3_NINES_COMP_EN
   input  logic                    in_comp,
`endif
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [4*NUM_DIGITS-1:0] out_bcd,
   output logic [CW-1:0]           out_count,
   output logic                    out_err,
   output logic [NUM_DIGITS-1:0]   out_err_mask
);

   pack_state_e             state_q, state_d;
   logic [4*NUM_DIGITS-1:0] bcd_q, bcd_d;
   logic [NUM_DIGITS-1:0]   mask_q, mask_d;
   logic [CW-1:0]           count_q, count_d;

   logic       digit_comp;
   logic [3:0] digit_bcd;
   logic       digit_err;
   logic       accept;
   logic       word_full;

`ifdef EX3_NINES_COMP_EN
   assign digit_comp = in_comp;
`else
   assign digit_comp = 1'b0;
`endif

   ex3_digit_decode u_decode (
      .ex3  (in_ex3),
      .comp (digit_comp),
      .bcd  (digit_bcd),
      .err  (digit_err)
   );

   assign in_ready  = (state_q == COLLECT);
   assign accept    = in_valid & in_ready;
   // This accept is the one that fills the last free nibble.
   assign word_full = (count_q == CW'(NUM_DIGITS - 1));

   // Next-state logic: shift digits in while collecting, clear on hand-off.
   always_comb begin
      // NOTE: every target gets a default first so no path leaves it unassigned, which would infer a latch.
      state_d = state_q;
      bcd_d   = bcd_q;
      mask_d  = mask_q;
      count_d = count_q;
      unique case (state_q)
         COLLECT: begin
            if (accept) begin
               bcd_d   = (bcd_q << 4) | {{(4*NUM_DIGITS-4){1'b0}}, digit_bcd};
               mask_d  = (mask_q << 1) | {{(NUM_DIGITS-1){1'b0}}, digit_err};
               count_d = count_q + 1'b1;
               if (in_last || word_full) begin
                  state_d = OUTPUT;
               end
            end
         end
         OUTPUT: begin
            if (out_ready) begin
               bcd_d   = '0;
               mask_d  = '0;
               count_d = '0;
               state_d = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   // State and word registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
      if (!rst_n) begin
         state_q <= COLLECT;
         bcd_q   <= '0;
         mask_q  <= '0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         bcd_q   <= bcd_d;
         mask_q  <= mask_d;
         count_q <= count_d;
      end
   end

   assign out_valid    = (state_q == OUTPUT);
   assign out_bcd      = bcd_q;
   assign out_count    = count_q;
   assign out_err_mask = mask_q;
   assign out_err      = |mask_q;

endmodule

// File: tb/tb_ex3_to_bcd_packer.sv
// Directed self-checking bench for ex3_to_bcd_packer (NUM_DIGITS = 4).
// The nine's-complement vectors run only when EX3_NINES_COMP_EN is defined.
module tb_ex3_to_bcd_packer;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  in_ex3;
   logic        in_last;
   logic        in_comp;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_bcd;
   logic [2:0]  out_count;
   logic        out_err;
   logic [3:0]  out_err_mask;

   int n_cmp = 0;
   int n_bad = 0;

   ex3_to_bcd_packer #(.NUM_DIGITS(4)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_ex3       (in_ex3),
      .in_last      (in_last),
`ifdef EX3_NINES_COMP_EN
      .in_comp      (in_comp),
`endif
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_bcd      (out_bcd),
      .out_count    (out_count),
      .out_err      (out_err),
      .out_err_mask (out_err_mask)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Present one digit and hold it until accepted; returns just after the accepting edge.
   task automatic send(input logic [3:0] d, input logic last, input logic comp);
      int waited = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_ex3   = d;
      in_last  = last;
      in_comp  = comp;
      while (!in_ready && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      if (!in_ready) check("send_timeout", 32'd0, 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      in_comp  = 1'b0;
   endtask

   // Wait (bounded) for a word, compare it, then consume it.
   task automatic expect_word(input string tag, input logic [15:0] bcd,
                              input logic [2:0] cnt, input logic [3:0] mask);
      int waited = 0;
      while (!out_valid && waited < 20) begin
         @(posedge clk);
         #1;
         waited++;
      end
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_bcd"},   32'(out_bcd),   32'(bcd));
      check({tag, "_count"}, 32'(out_count), 32'(cnt));
      check({tag, "_mask"},  32'(out_err_mask), 32'(mask));
      check({tag, "_err"},   32'(out_err),   32'(mask != 4'd0));
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check({tag, "_ready_after"}, 32'(in_ready),  32'd1);
      check({tag, "_cleared"},     32'(out_bcd),   32'd0);
   endtask

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_ex3    = 4'd0;
      in_last   = 1'b0;
      in_comp   = 1'b0;
      out_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_ready", 32'(in_ready),  32'd1);
      check("rst_count", 32'(out_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // Reset mid-word discards the partial word.
      send(4'h7, 1'b0, 1'b0);
      send(4'h8, 1'b0, 1'b0);
      check("mid_partial", 32'(out_bcd), 32'h0045);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_ready", 32'(in_ready),  32'd1);
      check("mid_rst_bcd",   32'(out_bcd),   32'd0);
      check("mid_rst_count", 32'(out_count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      send(4'h4, 1'b1, 1'b0);
      expect_word("after_rst", 16'h0001, 3'd1, 4'b0000);

      // Full word closes on count without in_last; valid one cycle after 4th accept.
      send(4'h4, 1'b0, 1'b0);
      send(4'h5, 1'b0, 1'b0);
      send(4'h6, 1'b0, 1'b0);
      check("full_not_yet", 32'(out_valid), 32'd0);
      send(4'hC, 1'b0, 1'b0);
      check("full_latency", 32'(out_valid), 32'd1);
      expect_word("full", 16'h1239, 3'd4, 4'b0000);

      // Short word; out_ready during COLLECT must not disturb collection.
      send(4'h8, 1'b0, 1'b0);
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("collect_ready_count", 32'(out_count), 32'd1);
      check("collect_ready_bcd",   32'(out_bcd),   32'h0005);
      send(4'h3, 1'b1, 1'b0);
      expect_word("short", 16'h0050, 3'd2, 4'b0000);

      // Invalid codes below and above the Excess-3 range.
      send(4'h2, 1'b0, 1'b0);
      send(4'h9, 1'b0, 1'b0);
      send(4'hD, 1'b0, 1'b0);
      send(4'h7, 1'b1, 1'b0);
      expect_word("invalid", 16'hF6F4, 3'd4, 4'b1010);

      // Backpressure: word held, source held, nothing accepted.
      send(4'h4, 1'b0, 1'b0);
      send(4'h5, 1'b0, 1'b0);
      send(4'h6, 1'b0, 1'b0);
      send(4'h7, 1'b0, 1'b0);
      @(negedge clk);
      in_valid = 1'b1;
      in_ex3   = 4'h8;
      in_last  = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk);
         #1;
         check("bp_ready", 32'(in_ready),  32'd0);
         check("bp_valid", 32'(out_valid), 32'd1);
         check("bp_bcd",   32'(out_bcd),   32'h1234);
         check("bp_count", 32'(out_count), 32'd4);
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("bp_release_ready", 32'(in_ready),  32'd1);
      check("bp_release_count", 32'(out_count), 32'd0);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_last  = 1'b0;
      expect_word("bp_fresh", 16'h0005, 3'd1, 4'b0000);

`ifdef EX3_NINES_COMP_EN
      // Nine's complement: 1->8, 9 straight, 0->9.
      send(4'h4, 1'b0, 1'b1);
      send(4'hC, 1'b0, 1'b0);
      send(4'h3, 1'b1, 1'b1);
      expect_word("comp", 16'h0899, 3'd3, 4'b0000);
      // Validity judged before complementing: 0x0 stays invalid.
      send(4'h0, 1'b1, 1'b1);
      expect_word("comp_invalid", 16'h000F, 3'd1, 4'b0001);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
